// File: rtl/ln_sfu_pkg.sv
// Shared types and constants for the layer-norm special-function sequencers:
// state encoding, stage indices and small state-decode helpers.
package ln_sfu_pkg;

  localparam int NUM_STAGES = 6;

  localparam int ST_SQ  = 0;
  localparam int ST_SUM = 1;
  localparam int ST_DIV = 2;
  localparam int ST_SUB = 3;
  localparam int ST_EPS = 4;
  localparam int ST_GAM = 5;

  // Stage states are numbered so that state code = stage index + 1.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SQ   = 4'd1,
    S_SUM  = 4'd2,
    S_DIV  = 4'd3,
    S_SUB  = 4'd4,
    S_EPS  = 4'd5,
    S_GAM  = 4'd6,
    S_RES  = 4'd7,
    S_ERR  = 4'd8
  } state_t;

  function automatic logic [2:0] state_code(input state_t s);
    return (s == S_ERR) ? 3'd7 : s[2:0];
  endfunction

  function automatic logic is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_ERR));
  endfunction

  function automatic logic is_stage(input state_t s);
    return (s >= S_SQ) && (s <= S_GAM);
  endfunction

endpackage

// File: rtl/ln_stage_timer.sv
// Per-stage timeout counter: loaded on a stage launch, counts while the stage
// waits for its done, flags once LIMIT cycles have elapsed. Built only with LN_SEQ_TIMEOUT_EN.
`ifdef LN_SEQ_TIMEOUT_EN
module ln_stage_timer #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_AT = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // The launch edge itself counts as the first elapsed cycle, so the state
  // machine sees hit in the last waiting cycle and reaches ERR LIMIT cycles after go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = run && (cnt >= HIT_AT);

endmodule
`endif

// File: rtl/ln_var_seq.sv
// Variance / gamma-scale sequencer: launches six arithmetic stages in order and
// hands back a result. Optional stage timeout enabled by LN_SEQ_TIMEOUT_EN.
module ln_var_seq
  import ln_sfu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  eq_valid_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  output logic [NUM_STAGES-1:0] stage_go_o,
  output logic [2:0]            stage_o,
  output logic                  busy_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o
);

  if (CNT_W < $clog2(TIMEOUT_CYC + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold TIMEOUT_CYC");
  end

  state_t                state, state_nxt;
  logic [NUM_STAGES-1:0] go_nxt;
  logic                  armed, armed_nxt;
  logic                  pending, pending_nxt;
  logic [2:0]            idx;
  logic                  go_now, advance, timeout_hit;

  // armed: the current stage has launched and its done may now be sampled.
  assign idx     = state[2:0] - 3'd1;
  assign go_now  = |stage_go_o;
  assign advance = is_stage(state) && armed && stage_done_i[idx];

`ifdef LN_SEQ_TIMEOUT_EN
  ln_stage_timer #(
    .LIMIT (TIMEOUT_CYC),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go_now),
    .clear (abort_i | advance),
    .run   (armed),
    .hit   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt   = state;
    go_nxt      = '0;
    armed_nxt   = armed;
    pending_nxt = pending;
    if (abort_i) begin
      state_nxt   = S_IDLE;
      armed_nxt   = 1'b0;
      pending_nxt = 1'b0;
    end else begin
      if (start_i && is_busy(state)) pending_nxt = 1'b1;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state_nxt      = S_SQ;
            go_nxt[ST_SQ]  = 1'b1;
          end
        end
        S_RES: begin
          if (ready_i) begin
            if (pending_nxt) begin
              state_nxt     = S_SQ;
              go_nxt[ST_SQ] = 1'b1;
              pending_nxt   = 1'b0;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_ERR: ;
        default: begin
          if (go_now) begin
            armed_nxt = 1'b1;
          end else if (advance) begin
            armed_nxt = 1'b0;
            if (state == S_GAM) begin
              state_nxt = S_RES;
            end else begin
              state_nxt = state_t'(state + 4'd1);
              // The subtract stage cannot launch until the external E^2 operand is valid.
              if ((state_nxt != S_SUB) || eq_valid_i)
                go_nxt = NUM_STAGES'(1) << (idx + 3'd1);
            end
          end else if (timeout_hit) begin
            state_nxt = S_ERR;
            armed_nxt = 1'b0;
          end else if ((state == S_SUB) && !armed && eq_valid_i) begin
            go_nxt[ST_SUB] = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      stage_go_o <= '0;
      stage_o    <= 3'd0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      armed      <= 1'b0;
      pending    <= 1'b0;
`ifdef LN_SEQ_TIMEOUT_EN
      err_o      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      stage_go_o <= go_nxt;
      stage_o    <= state_code(state_nxt);
      busy_o     <= is_busy(state_nxt);
      valid_o    <= (state_nxt == S_RES);
      armed      <= armed_nxt;
      pending    <= pending_nxt;
`ifdef LN_SEQ_TIMEOUT_EN
      err_o      <= (state_nxt == S_ERR);
`endif
    end
  end

endmodule

// File: tb/tb_ln_var_seq.sv
// Self-checking bench for ln_var_seq: table-driven pass scenarios scored through
// an event queue, plus hand-written abort, reset and (with LN_SEQ_TIMEOUT_EN) timeout sequences.
module tb_ln_var_seq;
  import ln_sfu_pkg::*;

  localparam int TO_CYC   = 8;
  localparam int EV_VALID = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start_i = 1'b0;
  logic                  abort_i = 1'b0;
  logic                  eq_valid_i = 1'b0;
  logic                  ready_i = 1'b0;
  logic [NUM_STAGES-1:0] stage_done_i = '0;
  logic [NUM_STAGES-1:0] stage_go_o;
  logic [2:0]            stage_o;
  logic                  busy_o, valid_o, err_o;

  ln_var_seq #(.TIMEOUT_CYC(TO_CYC), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .eq_valid_i   (eq_valid_i),
    .stage_done_i (stage_done_i),
    .stage_go_o   (stage_go_o),
    .stage_o      (stage_o),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // Scenario row: input schedule plus expected event list and valid_o duty.
  typedef struct {
    int start_a, start_b, start_c;
    int eqv_from, ready_from;
    int hold_k, hold_until;
    int run_len;
    int ev_base, ev_cnt;
    int valid_len;
  } row_t;

  // kind 0..5 = stage_go_o bit, kind 6 = valid_o rising; encoded as kind*1000+cycle in messages.
  typedef struct packed { int kind; int cyc; } ev_t;

  ev_t  ev_tab[64];
  int   ev_n = 0;
  row_t rows[6];
  int   n_rows = 0;
  ev_t  sb[$];

  function automatic void add_ev(input int k, input int c);
    ev_tab[ev_n] = '{kind: k, cyc: c};
    ev_n++;
  endfunction

  function automatic void add_pass(input int g0);
    for (int i = 0; i < NUM_STAGES; i++) add_ev(i, g0 + 2 * i);
    add_ev(EV_VALID, g0 + 12);
  endfunction

  function automatic row_t mk_row(input int s1, input int s2, input int s3, input int eqv,
                                  input int rdy, input int hk, input int hu, input int len,
                                  input int base, input int vlen);
    row_t x;
    x.start_a = s1; x.start_b = s2; x.start_c = s3;
    x.eqv_from = eqv; x.ready_from = rdy;
    x.hold_k = hk; x.hold_until = hu; x.run_len = len;
    x.ev_base = base; x.ev_cnt = ev_n - base; x.valid_len = vlen;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    eq_valid_i = 1'b0; ready_i = 1'b0; stage_done_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic expect_ev(input int r, input int k, input int c);
    ev_t e;
    if (sb.size() == 0) begin
      check($sformatf("row%0d extra event", r), k * 1000 + c, -1);
    end else begin
      e = sb.pop_front();
      check($sformatf("row%0d event", r), k * 1000 + c, e.kind * 1000 + e.cyc);
    end
  endtask

  task automatic run_row(input int r);
    row_t w;
    int   done_at[NUM_STAGES];
    int   valid_cnt, err_cnt;
    logic prev_valid;
    w = rows[r];
    valid_cnt = 0; err_cnt = 0; prev_valid = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) done_at[k] = -1;
    do_reset();
    for (int i = w.ev_base; i < w.ev_base + w.ev_cnt; i++) sb.push_back(ev_tab[i]);
    for (int c = 0; c < w.run_len; c++) begin
      tick();
      start_i    = (c == w.start_a) || (c == w.start_b) || (c == w.start_c);
      eq_valid_i = (c >= w.eqv_from);
      ready_i    = (c >= w.ready_from);
      for (int k = 0; k < NUM_STAGES; k++) stage_done_i[k] = (done_at[k] == c);
      @(negedge clk);
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stage_go_o[k]) begin
          expect_ev(r, k, c);
          done_at[k] = (k == w.hold_k) ? w.hold_until : c + 1;
        end
      end
      if (valid_o && !prev_valid) expect_ev(r, EV_VALID, c);
      prev_valid = valid_o;
      valid_cnt += int'(valid_o);
      err_cnt   += int'(err_o);
    end
    check($sformatf("row%0d missing events", r), sb.size(), 0);
    sb.delete();
    check($sformatf("row%0d valid cycles", r), valid_cnt, w.valid_len);
    check($sformatf("row%0d err cycles", r), err_cnt, 0);
    check($sformatf("row%0d final busy", r), int'(busy_o), 0);
    check($sformatf("row%0d final stage", r), int'(stage_o), 0);
  endtask

  initial begin
    int b, go_seen, busy_seen, err_rise;

    // Nominal single pass.
    b = ev_n; add_pass(1);
    rows[n_rows++] = mk_row(0, -1, -1, 0, 0, -1, 0, 20, b, 1);
    // SUB stall: eq_valid_i first sampled high at the edge opening cycle 20.
    b = ev_n;
    add_ev(0, 1); add_ev(1, 3); add_ev(2, 5);
    add_ev(3, 20); add_ev(4, 22); add_ev(5, 24); add_ev(EV_VALID, 26);
    rows[n_rows++] = mk_row(0, -1, -1, 19, 0, -1, 0, 32, b, 1);
    // Back-to-back: start at 4 is queued, start at 6 dropped.
    b = ev_n; add_pass(1); add_pass(14);
    rows[n_rows++] = mk_row(0, 4, 6, 0, 0, -1, 0, 32, b, 2);
    // Backpressure: ready_i low for cycles 13..22 while in RES.
    b = ev_n; add_pass(1);
    rows[n_rows++] = mk_row(0, -1, -1, 0, 23, -1, 0, 30, b, 11);
    // Start arriving during RES is queued and launched after the handshake.
    b = ev_n; add_pass(1); add_pass(18);
    rows[n_rows++] = mk_row(0, 15, -1, 0, 17, -1, 0, 36, b, 6);
`ifndef LN_SEQ_TIMEOUT_EN
    // Without the timeout, a long-withheld DIV done just stalls the pass.
    b = ev_n;
    add_ev(0, 1); add_ev(1, 3); add_ev(2, 5);
    add_ev(3, 51); add_ev(4, 53); add_ev(5, 55); add_ev(EV_VALID, 57);
    rows[n_rows++] = mk_row(0, -1, -1, 0, 0, 2, 50, 65, b, 1);
`endif

    #12;
    check("reset stage_go_o", int'(stage_go_o), 0);
    check("reset stage_o", int'(stage_o), 0);
    check("reset busy_o", int'(busy_o), 0);
    check("reset valid_o", int'(valid_o), 0);
    check("reset err_o", int'(err_o), 0);

    for (int r = 0; r < n_rows; r++) run_row(r);

    // Abort coinciding with SUM's done must return to IDLE without advancing.
    do_reset();
    eq_valid_i = 1'b1; ready_i = 1'b1; go_seen = 0;
    for (int c = 0; c <= 10; c++) begin
      tick();
      start_i      = (c == 0);
      stage_done_i = (c == 2) ? 6'b000001 : (c == 4) ? 6'b000010 : 6'b000000;
      abort_i      = (c == 4);
      @(negedge clk);
      if (c == 4) check("abort pre stage_o", int'(stage_o), 2);
      if (c == 5) begin
        check("abort stage_o", int'(stage_o), 0);
        check("abort busy_o", int'(busy_o), 0);
      end
      if (c >= 5) go_seen += int'(stage_go_o != '0);
    end
    check("abort no go after", go_seen, 0);

    // Asynchronous reset in the middle of SUM's launch cycle.
    do_reset();
    eq_valid_i = 1'b1; ready_i = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      tick();
      start_i      = (c == 0);
      stage_done_i = (c == 2) ? 6'b000001 : 6'b000000;
      @(negedge clk);
    end
    check("midpass stage_o", int'(stage_o), 2);
    check("midpass go", int'(stage_go_o), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst go", int'(stage_go_o), 0);
    check("async rst stage_o", int'(stage_o), 0);
    check("async rst busy/valid/err", int'({busy_o, valid_o, err_o}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    go_seen = 0; busy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      stage_done_i = 6'b000010;
      @(negedge clk);
      go_seen   += int'(stage_go_o != '0);
      busy_seen += int'(busy_o);
    end
    check("post reset no go", go_seen, 0);
    check("post reset no busy", busy_seen, 0);
    stage_done_i = '0;

`ifdef LN_SEQ_TIMEOUT_EN
    // DIV done withheld: ERR 8 cycles after go[2]; start ignored in ERR; abort clears.
    do_reset();
    eq_valid_i = 1'b1; ready_i = 1'b1; err_rise = -1;
    for (int c = 0; c <= 20; c++) begin
      tick();
      start_i      = (c == 0) || (c == 15);
      stage_done_i = (c == 2) ? 6'b000001 : (c == 4) ? 6'b000010 : 6'b000000;
      abort_i      = (c == 18);
      @(negedge clk);
      if (err_o && (err_rise < 0)) err_rise = c;
      if (c == 13) begin
        check("timeout busy_o", int'(busy_o), 0);
        check("timeout stage_o", int'(stage_o), 7);
      end
      if (c == 17) begin
        check("err holds err_o", int'(err_o), 1);
        check("err ignores start", int'(stage_o), 7);
      end
      if (c == 19) begin
        check("abort clears err_o", int'(err_o), 0);
        check("abort from err stage_o", int'(stage_o), 0);
        check("abort from err busy_o", int'(busy_o), 0);
      end
    end
    check("timeout err cycle", err_rise, 13);
    abort_i = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ln_var_seq.md
LN_VAR_SEQ -- requirements
Module: ln_var_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, giving max cycles a stage may wait for its done before error.
REQ-002 SHALL have parameter CNT_W, default 11, giving the timeout counter width; CNT_W SHALL be at least clog2(TIMEOUT_CYC+1).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  request one variance/gamma-scale pass.
REQ-006 SHALL have port abort_i  input  1  synchronous abort to IDLE.
REQ-007 SHALL have port eq_valid_i  input  1  E^2 operand valid (external mean path).
REQ-008 SHALL have port stage_done_i  input  6  per-stage completion, bit k = stage k.
REQ-009 SHALL have port stage_go_o  output  6  one-hot one-cycle stage launch pulse.
REQ-010 SHALL have port stage_o  output  3  current state code (debug).
REQ-011 SHALL have port busy_o  output  1  high in any state except IDLE and ERR.
REQ-012 SHALL have port valid_o  output  1  result ready (gamma-scaled reciprocal std).
REQ-013 SHALL have port ready_i  input  1  consumer accepts result.
REQ-014 SHALL have port err_o  output  1  stage timeout occurred.

Function
REQ-015 SHALL implement states IDLE, SQ(0), SUM(1), DIV(2), SUB(3), EPS(4), GAM(5), RES, ERR; stage k = square, two-half accumulate+combine, multiply by 1/dim, E^2 minus mean-square, add epsilon, rsqrt times gamma.
REQ-016 SHALL move IDLE->SQ on the edge after start_i=1.
REQ-017 SHALL assert stage_go_o[k] for exactly the first cycle in stage k; all other bits 0; registered output.
REQ-018 SHALL sample stage_done_i[k] only from the cycle after go; on 1, advance to stage k+1 (GAM -> RES) at that edge; bits other than k ignored.
REQ-019 SHALL, in SUB, withhold stage_go_o[3] until eq_valid_i=1; go pulses in the first cycle eq_valid_i=1, and the timeout counter starts at that go.
REQ-020 SHALL hold valid_o=1 in RES until ready_i=1; on valid_o&ready_i leave RES at that edge.
REQ-021 SHALL latch start_i seen while busy_o=1 or in RES into one pending flag (further starts dropped); on RES exit go to SQ if pending (clear flag) else IDLE.
REQ-022 SHALL ignore start_i in ERR.
REQ-023 SHALL, on abort_i=1 in any state, go to IDLE next edge, clear pending, counter, err_o; abort_i has priority over all other events in the same cycle.
REQ-024 SHALL give minimum latency start_i -> valid_o of 13 cycles (go/done 2 cycles per stage, eq_valid_i already high).
REQ-025 SHALL drive stage_o: IDLE=0, SQ..GAM=1..6, RES=7; ERR also reports 7 with err_o=1.

Reset
REQ-026 SHALL on rst_n=0 force IDLE, stage_go_o=0, stage_o=0, busy_o=0, valid_o=0, err_o=0, pending=0, counter=0, asynchronously; reset mid-pass discards the pass.

Configuration
REQ-027 SHALL, with LN_SEQ_TIMEOUT_EN defined, count cycles after each go; if count reaches TIMEOUT_CYC with no done, go to ERR with err_o=1 until abort_i or reset.
REQ-028 SHALL, without LN_SEQ_TIMEOUT_EN, omit the counter, never enter ERR, tie err_o to 0, wait indefinitely per stage.

Structure
REQ-029 SHALL place the state enum, stage index constants (ST_SQ..ST_GAM) and NUM_STAGES=6 in shared package ln_sfu_pkg.
REQ-030 SHALL be one module; the timeout counter MAY be sub-module ln_stage_timer (load on go, clear on done/abort, flag at TIMEOUT_CYC).

Verification
REQ-031 Nominal: start_i pulse at cycle 0, every done returned 1 cycle after go, eq_valid_i=1, ready_i=1 -> go bits 0..5 at cycles 1,3,5,7,9,11, valid_o at cycle 13, then IDLE.
REQ-032 SUB stall: eq_valid_i low until cycle 20 -> stage_go_o[3] at cycle 20, no timeout, valid_o follows 6 cycles after go[3].
REQ-033 Back-to-back: second start_i at cycle 4, third at cycle 6, ready_i=1 -> exactly two passes, second go[0] the cycle after first RES exit.
REQ-034 Backpressure: ready_i=0 for 10 cycles in RES -> valid_o held 10+ cycles, no new go pulses.
REQ-035 Timeout (macro on, TIMEOUT_CYC=8): withhold stage_done_i[2] -> err_o=1 8 cycles after go[2], busy_o=0; abort_i -> IDLE, err_o=0.
REQ-036 Reset/abort mid-pass: rst_n low during SUM -> all outputs 0 immediately; abort_i with simultaneous stage_done_i -> IDLE, no advance.
